// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT constants, controller FSM state encoding and write-delay helper.
package ntt_pkg;
    localparam int DATA_W    = 30;
    localparam int LOG_N_DEF = 10;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    function automatic int wr_delay(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction
endpackage

// File: rtl/ntt_addr_delay.sv
// ntt_addr_delay: DEPTH-stage clearable shift register carrying {valid, addr_a, addr_b} write tags.
//  clk, rst : clock, synchronous active-high clear
//  d_i      : tag entering the line
//  q_o      : tag leaving the line DEPTH cycles later
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sr_q [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) sr_q[n] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int n = 1; n < DEPTH; n++) sr_q[n] <= sr_q[n-1];
        end
    end
    assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/gs_intt_controller.sv
// gs_intt_controller: sequences one butterfly per cycle through an in-place Gentleman-Sande inverse NTT.
//  start_i          : pulse that begins a transform when idle
//  busy_o, done_o   : transform in progress / one-cycle completion pulse
//  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o : coefficient RAM and twiddle ROM read side
//  wr_en_o, wr_addr_a_o, wr_addr_b_o           : butterfly result write-back side
//  stage_o          : current stage (status)
module gs_intt_controller
    import ntt_pkg::*;
#(
    parameter int LOG_N      = LOG_N_DEF,
    parameter int BF_LATENCY = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       rd_en_o,
    output logic [LOG_N-1:0]           rd_addr_a_o,
    output logic [LOG_N-1:0]           rd_addr_b_o,
    output logic [LOG_N-2:0]           tw_addr_o,
    output logic                       wr_en_o,
    output logic [LOG_N-1:0]           wr_addr_a_o,
    output logic [LOG_N-1:0]           wr_addr_b_o,
    output logic [$clog2(LOG_N+1)-1:0] stage_o
);
    localparam int WR_DELAY = wr_delay(RD_LATENCY, BF_LATENCY);
    localparam int HALF     = 2 ** (LOG_N - 1);
    localparam int CW       = $clog2((HALF > WR_DELAY) ? HALF : WR_DELAY) + 1;
    localparam int SW       = $clog2(LOG_N + 1);
    localparam int TW       = 2 * LOG_N + 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             issue, last_issue, last_drain, last_stage;
    logic [LOG_N-1:0] i_ext, h, k, j;
    logic [LOG_N-2:0] tw;
    logic [TW-1:0]    tag_out;

    // cnt_q counts butterflies while issuing, then the write-back latency while draining
    assign issue      = state_q == ST_ISSUE;
    assign last_issue = cnt_q == CW'(HALF - 1);
    assign last_drain = cnt_q == CW'(WR_DELAY - 1);
    assign last_stage = stage_q == SW'(LOG_N - 1);

    // j = (i>>s)*2h + (i mod h) built from shifts and masks
    assign i_ext = {1'b0, cnt_q[LOG_N-2:0]};
    assign h     = LOG_N'(1) << stage_q;
    assign k     = i_ext & (h - 1'b1);
    assign j     = ((i_ext >> stage_q) << (stage_q + 1'b1)) | k;
    assign tw    = k[LOG_N-2:0] << (SW'(LOG_N - 1) - stage_q);

    // addresses are forced to zero outside ISSUE so idle outputs and idle tags are all-zero
    assign rd_en_o     = issue;
    assign rd_addr_a_o = issue ? j : '0;
    assign rd_addr_b_o = issue ? (j | h) : '0;
    assign tw_addr_o   = issue ? tw : '0;
    assign busy_o      = state_q != ST_IDLE;
    assign done_o      = state_q == ST_DONE;
    assign stage_o     = stage_q;

    ntt_addr_delay #(.WIDTH(TW), .DEPTH(WR_DELAY)) u_delay (
        .clk (clk),
        .rst (rst),
        .d_i ({issue, rd_addr_a_o, rd_addr_b_o}),
        .q_o (tag_out)
    );
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = tag_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                state_d = start_i ? ST_ISSUE : ST_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
            ST_ISSUE: begin
                state_d = last_issue ? ST_DRAIN : ST_ISSUE;
                cnt_d   = last_issue ? '0 : cnt_q + 1'b1;
            end
            ST_DRAIN: begin
                state_d = !last_drain ? ST_DRAIN : (last_stage ? ST_DONE : ST_ISSUE);
                cnt_d   = last_drain ? '0 : cnt_q + 1'b1;
                stage_d = (last_drain && !last_stage) ? stage_q + 1'b1 : stage_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end
endmodule

// File: tb/tb_gs_intt_controller.sv
// tb_gs_intt_controller: directed checks of the GS inverse-NTT controller at LOG_N=3 and LOG_N=10.
module tb_gs_intt_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sb;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] ra, rb, wa, wb;
    logic [1:0] tw, stg;
    logic       bbusy, bdone, brd_en, bwr_en;
    logic [9:0] bra, brb, bwa, bwb;
    logic [8:0] btw;
    logic [3:0] bstg;

    int n_assert = 0;
    int n_fail   = 0;

    int EA [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int EB [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int ET [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    gs_intt_controller #(.LOG_N(3), .BF_LATENCY(3), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb), .tw_addr_o(tw),
        .wr_en_o(wr_en), .wr_addr_a_o(wa), .wr_addr_b_o(wb), .stage_o(stg)
    );

    gs_intt_controller #(.LOG_N(10), .BF_LATENCY(12), .RD_LATENCY(1)) dut_big (
        .clk(clk), .rst(rst), .start_i(sb), .busy_o(bbusy), .done_o(bdone),
        .rd_en_o(brd_en), .rd_addr_a_o(bra), .rd_addr_b_o(brb), .tw_addr_o(btw),
        .wr_en_o(bwr_en), .wr_addr_a_o(bwa), .wr_addr_b_o(bwb), .stage_o(bstg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " rd_en"}, rd_en, 0);
        chk({tag, " rd_a"}, ra, 0);
        chk({tag, " rd_b"}, rb, 0);
        chk({tag, " tw"}, tw, 0);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_a"}, wa, 0);
        chk({tag, " wr_b"}, wb, 0);
        chk({tag, " stage"}, stg, 0);
    endtask

    // cycle c counts from 1 = first cycle after the edge that sampled start
    task automatic chk_cycle(input int c);
        int s, p, q;
        bit er, ew;
        s  = (c <= 24) ? (c - 1) / 8 : 2;
        p  = (c - 1) % 8;
        q  = p % 4;
        er = (c <= 24) && (p < 4);
        ew = (c <= 24) && (p >= 4);
        chk($sformatf("c%0d rd_en", c), rd_en, er);
        chk($sformatf("c%0d rd_a", c), ra, er ? EA[s][q] : 0);
        chk($sformatf("c%0d rd_b", c), rb, er ? EB[s][q] : 0);
        chk($sformatf("c%0d tw", c), tw, er ? ET[s][q] : 0);
        chk($sformatf("c%0d wr_en", c), wr_en, ew);
        chk($sformatf("c%0d wr_a", c), wa, ew ? EA[s][q] : 0);
        chk($sformatf("c%0d wr_b", c), wb, ew ? EB[s][q] : 0);
        chk($sformatf("c%0d busy", c), busy, c <= 25);
        chk($sformatf("c%0d done", c), done, c == 25);
        chk($sformatf("c%0d stage", c), stg, (c <= 25) ? s : 0);
    endtask

    task automatic run_trace(input bit extra);
        int nr, nw;
        int fr [3];
        int lw [3];
        nr = 0;
        nw = 0;
        fr = '{0, 0, 0};
        lw = '{0, 0, 0};
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            chk_cycle(c);
            if (rd_en && nr < 12) begin
                if (nr % 4 == 0) fr[nr/4] = c;
                nr++;
            end
            if (wr_en && nw < 12) begin
                lw[nw/4] = c;
                nw++;
            end
            start = extra && (c == 3 || c == 15);
        end
        chk("read count", nr, 12);
        chk("write count", nw, 12);
        chk("hazard s0->s1", fr[1] > lw[0], 1);
        chk("hazard s1->s2", fr[2] > lw[1], 1);
    endtask

    initial begin
        int bc [1024];
        int bnw, dc;
        rst   = 1'b1;
        start = 1'b0;
        sb    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset big wr_en", bwr_en, 0);
        chk("reset big busy", bbusy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        run_trace(1'b0);
        run_trace(1'b1);

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk_cycle(c);
            rst = (c == 10);
        end
        @(negedge clk);
        chk_idle("after rst");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post-rst wr_en", wr_en, 0);
            chk("post-rst done", done, 0);
        end
        run_trace(1'b0);

        for (int a = 0; a < 1024; a++) bc[a] = 0;
        bnw = 0;
        dc  = 0;
        sb  = 1'b1;
        @(posedge clk);
        #1 sb = 1'b0;
        for (int c = 1; c <= 6000 && dc == 0; c++) begin
            @(negedge clk);
            if (bwr_en) begin
                bc[bwa]++;
                bc[bwb]++;
                bnw++;
                if (bnw % 512 == 0)
                    for (int a = 0; a < 1024; a++) chk($sformatf("big addr %0d", a), bc[a], bnw / 512);
            end
            if (bdone) dc = c;
        end
        chk("big done cycle", dc, 5251);
        chk("big write count", bnw, 5120);
        @(negedge clk);
        chk("big idle after done", bbusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
